// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter: sprite/background read arbiter with CPU write path to graphics RAM.
// Optional GFXARB_ROUND_ROBIN_EN: round-robin reads; otherwise sprite has fixed priority.
module gfx_mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] sp_addr,
  input  logic        sp_valid,
  output logic        sp_ready,
  output logic [15:0] sp_data,
  input  logic [15:0] bg_addr,
  input  logic        bg_valid,
  output logic        bg_ready,
  output logic [15:0] bg_data,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_addr;
  logic [15:0] w_addr_nxt;
  logic        r_gnt_bg;
  logic        w_gnt_bg_nxt;
  logic        w_rd_start;
  logic        w_pick_bg;

  // A read starts only from IDLE when no write claims the cycle.
  assign w_rd_start = (r_state == IDLE) & ~wr_valid
                    & (sp_valid | bg_valid);

`ifdef GFXARB_ROUND_ROBIN_EN
  logic r_ptr_bg;

  // Pointer names the preferred port when both request.
  assign w_pick_bg = bg_valid & (~sp_valid | r_ptr_bg);

  // After each read grant the pointer moves to the port that lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr_bg <= 1'b0;
    end else if (w_rd_start) begin
      r_ptr_bg <= ~w_pick_bg;
    end
  end
`else
  assign w_pick_bg = bg_valid & ~sp_valid;
`endif

  // State, latched read address and granted-port register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_addr   <= 16'h0000;
      r_gnt_bg <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_gnt_bg <= w_gnt_bg_nxt;
    end
  end

  // Next-state logic and all outputs; reset forces outputs quiet.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_gnt_bg_nxt = r_gnt_bg;
    sp_ready     = 1'b0;
    sp_data      = 16'h0000;
    bg_ready     = 1'b0;
    bg_data      = 16'h0000;
    wr_ready     = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_rd_start) begin
          w_state_nxt  = RD;
          w_addr_nxt   = w_pick_bg ? bg_addr : sp_addr;
          w_gnt_bg_nxt = w_pick_bg;
        end
      end
      RD:      w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (!RST) begin
      mem_addr = r_addr;
      unique case (r_state)
        IDLE: begin
          if (wr_valid) begin
            mem_wr    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            wr_ready  = 1'b1;
          end
        end
        RD: mem_rd = 1'b1;
        ACK: begin
          if (r_gnt_bg) begin
            bg_ready = 1'b1;
            bg_data  = mem_rdata;
          end else begin
            sp_ready = 1'b1;
            sp_data  = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb_gfx_mem_arbiter: directed and random checks of gfx_mem_arbiter
// against a RAM model and a shadow-memory reference.
module tb_gfx_mem_arbiter;

`ifdef GFXARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] sp_addr = '0;
  logic        sp_valid = 1'b0;
  logic        sp_ready;
  logic [15:0] sp_data;
  logic [15:0] bg_addr = '0;
  logic        bg_valid = 1'b0;
  logic        bg_ready;
  logic [15:0] bg_data;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata = '0;

  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  wire [4:0] stat = {sp_ready, bg_ready, wr_ready, mem_rd, mem_wr};

  gfx_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .sp_addr(sp_addr), .sp_valid(sp_valid),
    .sp_ready(sp_ready), .sp_data(sp_data),
    .bg_addr(bg_addr), .bg_valid(bg_valid),
    .bg_ready(bg_ready), .bg_data(bg_data),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 CLK = ~CLK;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'haa55;
    return (a * 16'd7) ^ 16'h5a5a;
  endfunction

  // Graphics RAM: write on mem_wr, read data one cycle after mem_rd.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    forever begin
      @(posedge CLK);
      if (mem_wr) ram[mem_addr] = mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    sp_valid = 1'b1; bg_valid = 1'b1; wr_valid = 1'b1;
    wr_addr = 16'hbeef; wr_data = 16'hcafe;
    tick(); tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL reset_strobes got=%b exp=%b", stat, 5'b00000);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      n_bad++; $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({sp_data, bg_data} !== 32'h0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h exp=0/0", sp_data, bg_data);
    end
    tick();
    RST = 1'b0; sp_valid = 1'b0; bg_valid = 1'b0; wr_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL post_reset_idle got=%b exp=%b", stat, 5'b00000);
    end
  endtask

  task automatic test_sp_read();
    tick(); sp_valid = 1'b1; sp_addr = 16'h0010;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000 || sp_data !== 16'h0) begin
      n_bad++; $display("FAIL sp_read_c1 got=%b/%h exp=00000/0000", stat, sp_data);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00010 || mem_addr !== 16'h0010) begin
      n_bad++; $display("FAIL sp_read_c2 got=%b/%h exp=00010/0010", stat, mem_addr);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b10000 || sp_data !== 16'haa55 || bg_data !== 16'h0) begin
      n_bad++;
      $display("FAIL sp_read_c3 got=%b/%h exp=10000/aa55", stat, sp_data);
    end
    tick(); sp_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000 || sp_data !== 16'h0) begin
      n_bad++; $display("FAIL sp_read_c4 got=%b/%h exp=00000/0000", stat, sp_data);
    end
  endtask

  task automatic test_write_during_read();
    tick(); bg_valid = 1'b1; bg_addr = 16'h0040;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL wdr_c1 got=%b exp=00000", stat);
    end
    tick(); wr_valid = 1'b1; wr_addr = 16'h0200; wr_data = 16'h1234;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00010 || mem_addr !== 16'h0040) begin
      n_bad++; $display("FAIL wdr_c2 got=%b/%h exp=00010/0040", stat, mem_addr);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b01000 || bg_data !== shadow[16'h0040]) begin
      n_bad++;
      $display("FAIL wdr_c3 got=%b/%h exp=01000/%h", stat, bg_data, shadow[16'h0040]);
    end
    tick(); bg_valid = 1'b0; sp_valid = 1'b1; sp_addr = 16'h0200;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00101 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL wdr_c4 got=%b/%h/%h exp=00101/0200/1234", stat, mem_addr, mem_wdata);
    end
    shadow[16'h0200] = 16'h1234;
    tick(); wr_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL wdr_c5 got=%b exp=00000", stat);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00010 || mem_addr !== 16'h0200) begin
      n_bad++; $display("FAIL wdr_c6 got=%b/%h exp=00010/0200", stat, mem_addr);
    end
    tick();
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b10000 || sp_data !== 16'h1234) begin
      n_bad++; $display("FAIL wdr_c7 got=%b/%h exp=10000/1234", stat, sp_data);
    end
    tick(); sp_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL wdr_c8 got=%b exp=00000", stat);
    end
  endtask

  task automatic test_arbitration();
    logic [4:0]  exp_stat;
    logic        exp_bg;
    logic [15:0] exp_addr;
    int          idx;
    int          ph;
    tick(); RST = 1'b1;
    tick(); RST = 1'b0;
    sp_valid = 1'b1; bg_valid = 1'b1;
    sp_addr = 16'h0020; bg_addr = 16'h0030;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      @(negedge CLK);
      idx = (k - 1) / 3;
      ph = (k - 1) % 3;
      exp_bg = RR && (idx % 2 == 1);
      exp_addr = exp_bg ? 16'h0030 : 16'h0020;
      exp_stat = 5'b00000;
      if (ph == 1) exp_stat = 5'b00010;
      if (ph == 2) exp_stat = exp_bg ? 5'b01000 : 5'b10000;
      n_cmp++;
      if (stat !== exp_stat) begin
        n_bad++; $display("FAIL arb_k%0d got=%b exp=%b", k, stat, exp_stat);
      end
      if (ph == 1) begin
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_bad++; $display("FAIL arb_addr_k%0d got=%h exp=%h", k, mem_addr, exp_addr);
        end
      end
      if (ph == 2) begin
        n_cmp++;
        if ((exp_bg ? bg_data : sp_data) !== shadow[exp_addr]) begin
          n_bad++;
          $display("FAIL arb_data_k%0d got=%h/%h exp=%h", k, sp_data, bg_data, shadow[exp_addr]);
        end
      end
    end
    tick(); sp_valid = 1'b0; bg_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    logic [4:0] exp_stat;
    tick(); sp_valid = 1'b1; sp_addr = 16'h0050;
    @(negedge CLK);
    tick(); RST = 1'b1; sp_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL abort_rst got=%b exp=00000", stat);
    end
    tick(); RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL abort_after got=%b exp=00000", stat);
    end
    tick();
    sp_valid = 1'b1; bg_valid = 1'b1;
    sp_addr = 16'h0060; bg_addr = 16'h0070;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      @(negedge CLK);
      exp_stat = (k == 1) ? 5'b00000 : (k == 2) ? 5'b00010 : 5'b10000;
      n_cmp++;
      if (stat !== exp_stat) begin
        n_bad++; $display("FAIL abort_new_k%0d got=%b exp=%b", k, stat, exp_stat);
      end
    end
    n_cmp++;
    if (sp_data !== shadow[16'h0060]) begin
      n_bad++; $display("FAIL abort_new_data got=%h exp=%h", sp_data, shadow[16'h0060]);
    end
    tick(); sp_valid = 1'b0; bg_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (stat !== 5'b00000) begin
      n_bad++; $display("FAIL abort_tail got=%b exp=00000", stat);
    end
  endtask

  task automatic test_random();
    logic sp_p, bg_p, wr_p;
    int   sp_age, bg_age, wr_age;
    sp_p = 1'b0; bg_p = 1'b0; wr_p = 1'b0;
    sp_age = 0; bg_age = 0; wr_age = 0;
    for (int c = 0; c < 9000; c++) begin
      tick();
      if (!sp_p && $urandom_range(0, 7) == 0) begin
        sp_p = 1'b1; sp_age = 0;
        sp_addr = 16'($urandom_range(0, 127));
      end
      if (!bg_p && $urandom_range(0, 7) == 0) begin
        bg_p = 1'b1; bg_age = 0;
        bg_addr = 16'($urandom_range(0, 127));
      end
      if (!wr_p && $urandom_range(0, 7) == 0) begin
        wr_p = 1'b1; wr_age = 0;
        wr_addr = 16'($urandom_range(0, 127));
        wr_data = 16'($urandom);
      end
      sp_valid = sp_p; bg_valid = bg_p; wr_valid = wr_p;
      @(negedge CLK);
      n_cmp++;
      if ($countones({sp_ready, bg_ready, wr_ready}) > 1) begin
        n_bad++; $display("FAIL rnd_onehot c=%0d got=%b", c, stat);
      end
      n_cmp++;
      if (mem_rd && mem_wr) begin
        n_bad++; $display("FAIL rnd_overlap c=%0d got=%b", c, stat);
      end
      n_cmp++;
      if (wr_ready !== mem_wr) begin
        n_bad++; $display("FAIL rnd_wr_strobe c=%0d got=%b exp=%b", c, mem_wr, wr_ready);
      end
      n_cmp++;
      if (sp_ready) begin
        if (sp_p !== 1'b1 || sp_data !== shadow[sp_addr]) begin
          n_bad++;
          $display("FAIL rnd_sp c=%0d pend=%b got=%h exp=%h", c, sp_p, sp_data, shadow[sp_addr]);
        end
        sp_p = 1'b0;
      end else if (sp_data !== 16'h0) begin
        n_bad++; $display("FAIL rnd_sp_idle c=%0d got=%h exp=0000", c, sp_data);
      end
      n_cmp++;
      if (bg_ready) begin
        if (bg_p !== 1'b1 || bg_data !== shadow[bg_addr]) begin
          n_bad++;
          $display("FAIL rnd_bg c=%0d pend=%b got=%h exp=%h", c, bg_p, bg_data, shadow[bg_addr]);
        end
        bg_p = 1'b0;
      end else if (bg_data !== 16'h0) begin
        n_bad++; $display("FAIL rnd_bg_idle c=%0d got=%h exp=0000", c, bg_data);
      end
      if (wr_ready) begin
        n_cmp++;
        if (wr_p !== 1'b1 || mem_addr !== wr_addr || mem_wdata !== wr_data) begin
          n_bad++;
          $display("FAIL rnd_wr c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, wr_addr, wr_data);
        end
        shadow[wr_addr] = wr_data;
        wr_p = 1'b0;
      end
      if (sp_p) sp_age++;
      if (bg_p) bg_age++;
      if (wr_p) wr_age++;
      if (sp_age > 200 || bg_age > 200 || wr_age > 200) begin
        n_bad++;
        $display("FAIL rnd_timeout c=%0d ages=%0d/%0d/%0d limit=200", c, sp_age, bg_age, wr_age);
        sp_p = 1'b0; bg_p = 1'b0; wr_p = 1'b0;
        sp_age = 0; bg_age = 0; wr_age = 0;
      end
    end
    tick();
    sp_valid = 1'b0; bg_valid = 1'b0; wr_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(16'(i));
    test_reset();
    test_sp_read();
    test_write_during_read();
    test_arbitration();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
